// File: rtl/enigma_rotor_step.sv
// Enigma rotor stepping stage: advances left/middle/right rotor positions per key press and presents
// the right-rotor offset letter through a valid/ready register slice. Optional macro: ENIGMA_DOUBLE_STEP_EN.
module enigma_rotor_step #(
    parameter int LETTERS = 26,
    parameter int NOTCH_R = 21,
    parameter int NOTCH_M = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cfg_load,
    input  logic [4:0] cfg_pos_l,
    input  logic [4:0] cfg_pos_m,
    input  logic [4:0] cfg_pos_r,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [4:0] in_letter,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [4:0] out_letter,
    output logic [4:0] pos_l,
    output logic [4:0] pos_m,
    output logic [4:0] pos_r,
    output logic       err_invalid
);

    localparam logic [5:0] LETTERS_C = 6'(LETTERS);
    localparam logic [4:0] LAST_C    = 5'(LETTERS - 1);
    localparam logic [4:0] NOTCH_R_C = 5'(NOTCH_R);
    localparam logic [4:0] NOTCH_M_C = 5'(NOTCH_M);

    function automatic logic is_legal(input logic [4:0] v);
        return ({1'b0, v} < LETTERS_C);
    endfunction

    function automatic logic [4:0] sanitize(input logic [4:0] v);
        if (is_legal(v)) begin
            return v;
        end else begin
            return 5'd0;
        end
    endfunction

    function automatic logic [4:0] step_pos(input logic [4:0] p);
        if (p >= LAST_C) begin
            return 5'd0;
        end else begin
            return p + 5'd1;
        end
    endfunction

    // Both operands are already below LETTERS, so one conditional subtraction suffices.
    function automatic logic [4:0] add_mod(input logic [4:0] a, input logic [4:0] b);
        logic [5:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= LETTERS_C) begin
            sum = sum - LETTERS_C;
        end else begin
            sum = sum;
        end
        return sum[4:0];
    endfunction

    logic [4:0] pos_l_q, pos_m_q, pos_r_q;
    logic [4:0] pos_l_d, pos_m_d, pos_r_d;
    logic       out_valid_q, out_valid_d;
    logic [4:0] out_letter_q, out_letter_d;
    logic       err_q, err_d;

    logic       accept_s;
    logic       letter_ok_s;
    logic       step_m_s;
    logic       step_l_s;
    logic [4:0] pos_r_next_s;

    assign in_ready     = !cfg_load && (!out_valid_q || out_ready);
    assign accept_s     = in_valid && in_ready;
    assign letter_ok_s  = is_legal(in_letter);
    assign pos_r_next_s = step_pos(pos_r_q);

`ifdef ENIGMA_DOUBLE_STEP_EN
    // Historical double step: a middle rotor sitting on its notch drags itself and the left rotor along.
    assign step_m_s = (pos_r_q == NOTCH_R_C) || (pos_m_q == NOTCH_M_C);
    assign step_l_s = (pos_m_q == NOTCH_M_C);
`else
    assign step_m_s = (pos_r_q == NOTCH_R_C);
    assign step_l_s = step_m_s && (pos_m_q == NOTCH_M_C);
`endif

    // Next-state for rotor positions, output slice and error pulse.
    always_comb begin
        pos_l_d      = pos_l_q;
        pos_m_d      = pos_m_q;
        pos_r_d      = pos_r_q;
        out_valid_d  = out_valid_q;
        out_letter_d = out_letter_q;
        err_d        = 1'b0;

        if (cfg_load) begin
            pos_l_d = sanitize(cfg_pos_l);
            pos_m_d = sanitize(cfg_pos_m);
            pos_r_d = sanitize(cfg_pos_r);
            err_d   = !is_legal(cfg_pos_l) || !is_legal(cfg_pos_m) || !is_legal(cfg_pos_r);
        end else if (accept_s && letter_ok_s) begin
            pos_r_d = pos_r_next_s;
            if (step_m_s) begin
                pos_m_d = step_pos(pos_m_q);
            end else begin
                pos_m_d = pos_m_q;
            end
            if (step_l_s) begin
                pos_l_d = step_pos(pos_l_q);
            end else begin
                pos_l_d = pos_l_q;
            end
        end else if (accept_s) begin
            err_d = 1'b1;
        end else begin
            err_d = 1'b0;
        end

        if (accept_s && letter_ok_s) begin
            out_valid_d  = 1'b1;
            out_letter_d = add_mod(in_letter, pos_r_next_s);
        end else if (out_valid_q && out_ready) begin
            out_valid_d  = 1'b0;
        end else begin
            out_valid_d  = out_valid_q;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_l_q      <= 5'd0;
            pos_m_q      <= 5'd0;
            pos_r_q      <= 5'd0;
            out_valid_q  <= 1'b0;
            out_letter_q <= 5'd0;
            err_q        <= 1'b0;
        end else begin
            pos_l_q      <= pos_l_d;
            pos_m_q      <= pos_m_d;
            pos_r_q      <= pos_r_d;
            out_valid_q  <= out_valid_d;
            out_letter_q <= out_letter_d;
            err_q        <= err_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_letter  = out_letter_q;
    assign pos_l       = pos_l_q;
    assign pos_m       = pos_m_q;
    assign pos_r       = pos_r_q;
    assign err_invalid = err_q;

endmodule

// File: doc/enigma_rotor_step.md
Name: enigma_rotor_step

Overview:
- Sequential stage directly upstream of the combinational rotor reverse-permutation logic.
- Accepts one 5-bit letter code per key press and advances three rotor positions (left/middle/right) using Enigma stepping rules.
- Presents the position-offset letter, (letter + right position) mod 26, to the permutation stage through a valid/ready register slice.
- Also exposes current rotor positions for downstream offset removal and display.

Parameters:
- LETTERS, 26, alphabet size; legal codes 0..LETTERS-1 (A=0).
- NOTCH_R, 21, right-rotor turnover position (V).
- NOTCH_M, 4, middle-rotor turnover position (E).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cfg_load  input  1  load initial rotor positions.
- cfg_pos_l  input  5  initial left position.
- cfg_pos_m  input  5  initial middle position.
- cfg_pos_r  input  5  initial right position.
- in_valid  input  1  key-press letter valid.
- in_ready  output  1  stage can accept a letter.
- in_letter  input  5  plaintext letter code.
- out_valid  output  1  offset letter valid.
- out_ready  input  1  downstream accepts.
- out_letter  output  5  offset letter to the permutation stage.
- pos_l  output  5  current left position.
- pos_m  output  5  current middle position.
- pos_r  output  5  current right position.
- err_invalid  output  1  one-cycle pulse on an illegal code.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: pos_l/m/r=0, out_valid=0, out_letter=0, err_invalid=0.
- in_ready = !cfg_load && (!out_valid || out_ready). This is combinational and allows back-to-back acceptance every cycle.
- Accept means in_valid && in_ready at a clock edge. Latency is 1 cycle: out_valid rises on the edge after acceptance.
- Stepping on an accept with a legal letter, all evaluated from pre-step positions:
  - R always steps.
  - M steps if R==NOTCH_R, or if M==NOTCH_M (double step).
  - L steps if M==NOTCH_M.
  - Each position wraps LETTERS-1 -> 0.
- Offset arithmetic: out_letter = (in_letter + new pos_r) mod LETTERS. Compute with a 6-bit sum and subtract LETTERS if the sum is >= LETTERS. The result is always 0..25.
- Illegal letter (in_letter >= LETTERS) on accept:
  - The letter is consumed.
  - No stepping occurs and no output is produced.
  - err_invalid pulses for 1 cycle.
- Output register: out_valid and out_letter are held stable until out_valid && out_ready. A drain with no new accept clears out_valid; a drain plus a new accept in the same cycle reloads out_letter and keeps out_valid=1.
- cfg_load:
  - Takes priority; no letter is accepted that cycle.
  - Positions are loaded at the next edge.
  - Any cfg value >= LETTERS loads as 0 and pulses err_invalid.
  - A pending out_valid/out_letter is retained unchanged.
- Position outputs: pos_* are registers and reflect post-step values in the same cycle out_valid rises.
- Reset mid-operation: all state returns to reset values immediately and any pending output is discarded.

Optional Feature:
- Macro: ENIGMA_DOUBLE_STEP_EN.
- Defined: historical double-step as specified above.
- Undefined: pure odometer stepping.
  - M steps only when R==NOTCH_R.
  - L steps only when M==NOTCH_M and M also steps that cycle.
  - The M==NOTCH_M self-step term is removed.

Test Plan:
- Reset mid-stream: rst_n low with out_valid=1 -> out_valid=0 and pos=0,0,0 immediately, without waiting for a clock edge.
- Double-step sequence: load L,M,R=0,3,20 (ADU) and press A three times with out_ready=1.
  - Positions go 0,3,21 -> 0,4,22 -> 1,5,23 (ADV, AEW, BFX).
  - out_letter = 21, 22, 23.
  - With ENIGMA_DOUBLE_STEP_EN undefined, the third position is 0,4,23.
- Wrap: load 0,0,24 and press letter 25 -> pos_r=25, out_letter=24. Next press letter 1 -> pos_r=0, out_letter=1, pos_m unchanged.
- Backpressure: out_ready=0 with one letter pending -> in_ready=0, out_letter stable, positions frozen over 5 cycles. Assert out_ready with in_valid held -> drain and accept occur in the same cycle, out_valid stays 1.
- Illegal input: in_letter=27 -> err_invalid pulses 1 cycle, positions unchanged, out_valid stays 0.
- Config conflict: cfg_load together with in_valid and cfg_pos_r=30 -> in_ready=0, pos_r=0, err_invalid pulses, pending output retained.
